// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory-port arbiter: FSM encodings and requester indices.
package mem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_XFER  = 2'd1;
  localparam logic [1:0] ARB_DRAIN = 2'd2;
  localparam logic [1:0] ARB_DONE  = 2'd3;

  localparam int FETCH = 0;
  localparam int VLS   = 1;
  localparam int SST   = 2;

  localparam int LEN_W = 4;

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping mod NREQ.
module mem_arbiter_rr_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            found
);

  int c;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    c      = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = (int'(ptr) + k) % NREQ;
      if (!found && req[c]) begin
        found     = 1'b1;
        onehot[c] = 1'b1;
        idx       = IW'(c);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between NREQ requesters with round-robin, non-preemptable bursts
// of 1..16 beats; read data returns RD_LAT edges after issue and is drained before DONE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic                  Clk1,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*AW-1:0]    base,
  input  logic [NREQ*LEN_W-1:0] len,
  input  logic [NREQ*DW-1:0]    wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       wnext,
  output logic [DW-1:0]         rdata,
  output logic [NREQ-1:0]       rvalid,
  output logic [NREQ-1:0]       done,
  output logic [AW-1:0]         Addr,
  output logic                  RD,
  output logic                  WR,
  output logic [DW-1:0]         DataOut,
  input  logic [DW-1:0]         DataIn
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  logic [1:0]        state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     cur;
  logic              we_l;
  logic [AW-1:0]     base_l;
  logic [LEN_W-1:0]  len_l;
  logic [LEN_W-1:0]  cnt;
  logic [RD_LAT-1:0] vpipe;
  logic [NREQ-1:0]   win_oh;
  logic [IW-1:0]     win_idx;
  logic              win_any;
  logic [IW-1:0]     ptr_nxt;
  logic              issue_rd;

  mem_arbiter_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req    (req),
    .ptr    (ptr),
    .onehot (win_oh),
    .idx    (win_idx),
    .found  (win_any)
  );

  assign ptr_nxt  = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
  assign issue_rd = (state == ARB_XFER) && !we_l;
  assign wnext    = (state == ARB_XFER && we_l) ? gnt : '0;
  assign done     = (state == ARB_DONE) ? gnt : '0;

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state   <= ARB_IDLE;
      ptr     <= '0;
      cur     <= '0;
      we_l    <= 1'b0;
      base_l  <= '0;
      len_l   <= '0;
      cnt     <= '0;
      vpipe   <= '0;
      gnt     <= '0;
      rvalid  <= '0;
      rdata   <= '0;
      Addr    <= '0;
      RD      <= 1'b0;
      WR      <= 1'b0;
      DataOut <= '0;
    end else begin
      RD     <= 1'b0;
      WR     <= 1'b0;
      vpipe  <= (vpipe << 1) | RD_LAT'(issue_rd);
      // The oldest stage marks the edge at which memory data for that beat is valid.
      rvalid <= vpipe[RD_LAT-1] ? gnt : '0;
      if (vpipe[RD_LAT-1]) rdata <= DataIn;

      case (state)
        ARB_IDLE: begin
          if (win_any) begin
            cur    <= win_idx;
            we_l   <= we[win_idx];
            base_l <= base[int'(win_idx)*AW +: AW];
            len_l  <= len[int'(win_idx)*LEN_W +: LEN_W];
            cnt    <= '0;
            gnt    <= win_oh;
            ptr    <= ptr_nxt;
            state  <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          Addr <= base_l + AW'(cnt);
          RD   <= !we_l;
          WR   <= we_l;
          if (we_l) DataOut <= wdata[int'(cur)*DW +: DW];
          cnt  <= cnt + 1'b1;
          if (cnt == len_l) state <= we_l ? ARB_DONE : ARB_DRAIN;
        end
        ARB_DRAIN: begin
          if (vpipe == '0) state <= ARB_DONE;
        end
        ARB_DONE: begin
          gnt   <= '0;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single bursts, round-robin and mid-burst reset sequences,
// plus an RD_LAT=3 instance; a scoreboard checks every memory beat and every read return.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        Clk1, Reset;
  logic [2:0]  req, we, gnt, wnext, rvalid, done;
  logic [47:0] base, wdata;
  logic [11:0] len;
  logic [15:0] rdata, Addr, DataOut, DataIn;
  logic        RD, WR;

  logic [2:0]  req3, we3, gnt3, wnext3, rvalid3, done3;
  logic [47:0] base3, wdata3;
  logic [11:0] len3;
  logic [15:0] rdata3, Addr3, DataOut3, DataIn3;
  logic        RD3, WR3;

  mem_arbiter #(.NREQ(3), .AW(16), .DW(16), .RD_LAT(1)) dut (
    .Clk1(Clk1), .Reset(Reset), .req(req), .we(we), .base(base), .len(len), .wdata(wdata),
    .gnt(gnt), .wnext(wnext), .rdata(rdata), .rvalid(rvalid), .done(done),
    .Addr(Addr), .RD(RD), .WR(WR), .DataOut(DataOut), .DataIn(DataIn));

  mem_arbiter #(.NREQ(3), .AW(16), .DW(16), .RD_LAT(3)) dut3 (
    .Clk1(Clk1), .Reset(Reset), .req(req3), .we(we3), .base(base3), .len(len3), .wdata(wdata3),
    .gnt(gnt3), .wnext(wnext3), .rdata(rdata3), .rvalid(rvalid3), .done(done3),
    .Addr(Addr3), .RD(RD3), .WR(WR3), .DataOut(DataOut3), .DataIn(DataIn3));

  initial begin
    Clk1 = 1'b0;
    forever #5 Clk1 = ~Clk1;
  end

  function automatic logic [15:0] mf(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] wf(input int p, input int b);
    return 16'(p * 4096 + 'h0B00 + b);
  endfunction

  int nvec, nerr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory models: zero-wait for dut, three-edge pipeline for dut3.
  assign DataIn = mf(Addr);
  logic [15:0] q3 [3];
  assign DataIn3 = mf(q3[2]);
  initial begin
    q3[0] = 16'h0; q3[1] = 16'h0; q3[2] = 16'h0;
    forever begin
      @(negedge Clk1);
      q3[2] = q3[1]; q3[1] = q3[0]; q3[0] = Addr3;
    end
  end

  // Write-data source: each port advances its beat index whenever wnext was seen.
  int wb [3];
  logic [2:0] gs, ws;
  initial begin
    gs = '0; ws = '0;
    for (int i = 0; i < 3; i++) begin wb[i] = 0; wdata[i*16 +: 16] = wf(i, 0); end
    forever begin
      @(negedge Clk1); gs = gnt; ws = wnext;
      @(posedge Clk1); #1;
      for (int i = 0; i < 3; i++) begin
        if (!gs[i]) wb[i] = 0;
        else if (ws[i]) wb[i] = wb[i] + 1;
        wdata[i*16 +: 16] = wf(i, wb[i]);
      end
    end
  end

  typedef struct { logic [15:0] addr; bit wr; logic [15:0] dat; } beat_t;
  typedef struct { int port; logic [15:0] dat; } rv_t;
  beat_t aq[$];
  rv_t   rq[$];
  beat_t mb;
  rv_t   mr;

  task automatic expect_burst(input int p, input bit wr, input logic [15:0] b, input logic [3:0] l);
    for (int k = 0; k <= int'(l); k++) begin
      aq.push_back('{addr: 16'(b + k), wr: wr, dat: wr ? wf(p, k) : 16'h0});
      if (!wr) rq.push_back('{port: p, dat: mf(16'(b + k))});
    end
  endtask

  task automatic set_port(input int p, input bit wr, input logic [15:0] b, input logic [3:0] l);
    we[p] = wr;
    base[p*16 +: 16] = b;
    len[p*4 +: 4] = l;
  endtask

  always @(negedge Clk1) begin
    if (!Reset) begin
      chk("rd_wr_exclusive", 32'(RD & WR), 0);
      chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
      if (RD || WR) begin
        if (aq.size() == 0) chk("beat_unexpected", 32'({RD, WR}), 0);
        else begin
          mb = aq.pop_front();
          chk("beat_addr", 32'(Addr), 32'(mb.addr));
          chk("beat_wr", 32'(WR), 32'(mb.wr));
          if (mb.wr) chk("beat_dataout", 32'(DataOut), 32'(mb.dat));
        end
      end
      if (rvalid != 0) begin
        if (rq.size() == 0) chk("rvalid_unexpected", 32'(rvalid), 0);
        else begin
          mr = rq.pop_front();
          chk("rvalid_port", 32'(rvalid), 32'(1 << mr.port));
          chk("rdata", 32'(rdata), 32'(mr.dat));
        end
      end
    end
  end

  // Follows a granted burst from its first gnt cycle until gnt drops.
  task automatic run_tail(input int port, input bit rd, input int exp_cyc, input bit drop);
    int cyc, dcnt, dat, frv;
    cyc = 0; dcnt = 0; dat = 0; frv = 0;
    while (gnt != 0 && cyc < 40) begin
      cyc++;
      if (done != 0) begin
        dcnt++; dat = cyc;
        chk("done_port", 32'(done), 32'(1 << port));
        if (drop) req[port] = 1'b0;
      end
      if (rvalid != 0 && frv == 0) frv = cyc;
      @(negedge Clk1);
    end
    chk("burst_cycles", 32'(cyc), 32'(exp_cyc));
    chk("done_count", 32'(dcnt), 1);
    chk("done_last_cycle", 32'(dat), 32'(cyc));
    if (rd) chk("first_rvalid_cycle", 32'(frv), 3);
  endtask

  typedef struct { int port; bit wr; logic [15:0] base; logic [3:0] len; int cyc; } vec_t;
  vec_t tv [6];
  int   ord [4];
  int   gap, c, dc, gc;
  int   rdc[$], rvc[$];
  logic [15:0] ra[$], rvd[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nvec = 0; nerr = 0;
    Reset = 1'b1; req = '0; we = '0; base = '0; len = '0;
    req3 = '0; we3 = '0; base3 = '0; len3 = '0; wdata3 = '0;

    tv[0] = '{FETCH, 1'b0, 16'h0040, 4'd0,  4};
    tv[1] = '{VLS,   1'b0, 16'h0100, 4'd15, 19};
    tv[2] = '{FETCH, 1'b1, 16'h1234, 4'd1,  3};
    tv[3] = '{VLS,   1'b1, 16'h2000, 4'd0,  2};
    tv[4] = '{SST,   1'b0, 16'hFFFF, 4'd2,  6};
    tv[5] = '{SST,   1'b1, 16'hFFFE, 4'd3,  5};

    repeat (3) @(negedge Clk1);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_wr", 32'({RD, WR}), 0);
    chk("rst_addr", 32'(Addr), 0);
    chk("rst_dataout", 32'(DataOut), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_gnt3", 32'(gnt3), 0);
    Reset = 1'b0;
    @(negedge Clk1);

    for (int v = 0; v < 6; v++) begin
      expect_burst(tv[v].port, tv[v].wr, tv[v].base, tv[v].len);
      set_port(tv[v].port, tv[v].wr, tv[v].base, tv[v].len);
      req[tv[v].port] = 1'b1;
      for (int t = 0; t < 20 && gnt == 0; t++) @(negedge Clk1);
      chk("vec_gnt", 32'(gnt), 32'(1 << tv[v].port));
      run_tail(tv[v].port, !tv[v].wr, tv[v].cyc, 1'b1);
      chk("vec_beats_left", 32'(aq.size()), 0);
      chk("vec_reads_left", 32'(rq.size()), 0);
      req = '0;
    end

    // All three requesting continuously: expect 0,1,2,0 with one idle cycle between bursts.
    ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 0;
    for (int g = 0; g < 4; g++) expect_burst(ord[g], 1'b0, 16'(16'h0200 + ord[g] * 16), 4'd0);
    for (int p = 0; p < 3; p++) set_port(p, 1'b0, 16'(16'h0200 + p * 16), 4'd0);
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      gap = 0;
      while (gnt == 0 && gap < 20) begin gap++; @(negedge Clk1); end
      chk("rr_order", 32'(gnt), 32'(1 << ord[g]));
      if (g > 0) chk("rr_idle_gap", 32'(gap), 1);
      if (g == 3) req = '0;
      run_tail(ord[g], 1'b1, 4, 1'b0);
    end
    chk("rr_beats_left", 32'(aq.size()), 0);
    chk("rr_reads_left", 32'(rq.size()), 0);

    // Reset in the middle of a 16-beat read.
    expect_burst(VLS, 1'b0, 16'h0300, 4'd15);
    set_port(VLS, 1'b0, 16'h0300, 4'd15);
    req = 3'b010;
    for (int t = 0; t < 20 && gnt == 0; t++) @(negedge Clk1);
    chk("midrst_gnt", 32'(gnt), 32'b010);
    repeat (5) @(negedge Clk1);
    Reset = 1'b1;
    @(negedge Clk1);
    chk("midrst_rd_wr", 32'({RD, WR}), 0);
    chk("midrst_gnt_cleared", 32'(gnt), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_rvalid", 32'(rvalid), 0);
    aq.delete(); rq.delete();
    Reset = 1'b0; req = '0;
    for (int t = 0; t < 3; t++) begin
      @(negedge Clk1);
      chk("postrst_done", 32'(done), 0);
      chk("postrst_rvalid", 32'(rvalid), 0);
    end
    expect_burst(FETCH, 1'b0, 16'h0400, 4'd0);
    set_port(FETCH, 1'b0, 16'h0400, 4'd0);
    set_port(VLS, 1'b0, 16'h0410, 4'd0);
    set_port(SST, 1'b0, 16'h0420, 4'd0);
    req = 3'b111;
    for (int t = 0; t < 20 && gnt == 0; t++) @(negedge Clk1);
    chk("postrst_first_gnt", 32'(gnt), 32'b001);
    req = 3'b001;
    run_tail(FETCH, 1'b1, 4, 1'b1);
    chk("postrst_beats_left", 32'(aq.size()), 0);
    req = '0;

    // Three-edge memory latency: rvalid trails each RD by 3 cycles, DONE only after the last.
    base3[15:0] = 16'h0500; len3[3:0] = 4'd2; we3 = '0; req3 = 3'b001;
    dc = 0; gc = 0;
    for (c = 1; c <= 24; c++) begin
      @(negedge Clk1);
      if (RD3) begin rdc.push_back(c); ra.push_back(Addr3); end
      if (rvalid3 != 0) begin rvc.push_back(c); rvd.push_back(rdata3); end
      if (done3 != 0) begin dc = c; req3 = '0; end
      if (gnt3 != 0) gc++;
    end
    chk("lat3_rd_count", 32'(rdc.size()), 3);
    chk("lat3_rvalid_count", 32'(rvc.size()), 3);
    for (int k = 0; k < 3 && k < rdc.size() && k < rvc.size(); k++) begin
      chk("lat3_rvalid_delay", 32'(rvc[k] - rdc[k]), 3);
      chk("lat3_addr", 32'(ra[k]), 32'(16'h0500 + k));
      chk("lat3_rdata", 32'(rvd[k]), 32'(mf(16'(16'h0500 + k))));
    end
    if (rvc.size() > 0) chk("lat3_done_after_last_rvalid", 32'(dc), 32'(rvc[rvc.size()-1] + 1));
    chk("lat3_gnt_cycles", 32'(gc), 8);

    repeat (2) @(negedge Clk1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
